// File: rtl/bnn_sequencer_if.sv
// Issue/result bundle between decode and the BNN sequencer.
// master = issuer (decode), slave = bnn_sequencer.
interface bnn_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 6
);
  logic              ms_we_i;
  logic [2:0]        ms_wdata_i;
  logic              start_i;
  logic              en_threshold_i;
  logic [DATA_W-1:0] op_a_i;
  logic [DATA_W-1:0] op_b_i;
  logic [ACC_W-1:0]  threshold_i;
  logic              flush_i;
  logic [2:0]        ms_o;
  logic              busy_o;
  logic              stall_o;
  logic              done_o;
  logic [DATA_W-1:0] result_o;

  modport master (
    output ms_we_i, ms_wdata_i, start_i,
    output en_threshold_i, op_a_i, op_b_i,
    output threshold_i, flush_i,
    input  ms_o, busy_o, stall_o, done_o,
    input  result_o
  );

  modport slave (
    input  ms_we_i, ms_wdata_i, start_i,
    input  en_threshold_i, op_a_i, op_b_i,
    input  threshold_i, flush_i,
    output ms_o, busy_o, stall_o, done_o,
    output result_o
  );
endinterface

// File: rtl/bnn_sequencer.sv
// XNOR-popcount sequencer: BCNV/BNN, one kernel row per cycle.
// Ports: clk, reset_n (async low), bus (slave: issue + result).
// Option BNN_SEQ_BIPOLAR_EN: BCNV returns 2*acc - ms^2 (signed).
module bnn_sequencer #(
  parameter int DATA_W = 32,
  parameter int MAX_MS = 5,
  parameter int ACC_W  = $clog2(MAX_MS*MAX_MS+1)
) (
  input  logic           clk,
  input  logic           reset_n,
  bnn_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t            state;
  logic [2:0]        ms_r;
  logic [2:0]        ms_run;
  logic [2:0]        row;
  logic [DATA_W-1:0] sa;
  logic [DATA_W-1:0] sb;
  logic              thr_en;
  logic [ACC_W-1:0]  thr;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  pc;
  logic [ACC_W-1:0]  acc_nx;
  logic              done;
  logic [DATA_W-1:0] result;
  logic              ms_ok;
  logic [2:0]        ms_eff;
  logic [DATA_W-1:0] res_nx;

  assign ms_ok = bus.ms_we_i
              && bus.ms_wdata_i != 3'd0
              && bus.ms_wdata_i <= 3'(MAX_MS);
  assign ms_eff = ms_ok ? bus.ms_wdata_i : ms_r;

  // Only the low ms_run bits hold the current row.
  always_comb begin
    pc = '0;
    for (int i = 0; i < MAX_MS; i++) begin
      if (i < int'(ms_run) && (sa[i] ~^ sb[i]))
        pc = pc + ACC_W'(1);
    end
  end

  assign acc_nx = acc + pc;

  always_comb begin
    res_nx = DATA_W'(acc_nx);
    if (thr_en) begin
      res_nx = {{(DATA_W-1){1'b0}}, acc_nx >= thr};
    end else begin
`ifdef BNN_SEQ_BIPOLAR_EN
      // Modular arithmetic yields the sign-extended value.
      res_nx = (DATA_W'(acc_nx) << 1)
             - DATA_W'(ms_run) * DATA_W'(ms_run);
`else
      res_nx = DATA_W'(acc_nx);
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      ms_r   <= 3'(MAX_MS);
      ms_run <= '0;
      row    <= '0;
      sa     <= '0;
      sb     <= '0;
      thr_en <= 1'b0;
      thr    <= '0;
      acc    <= '0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      if (ms_ok)
        ms_r <= bus.ms_wdata_i;
      done <= 1'b0;
      if (bus.flush_i) begin
        state <= IDLE;
        acc   <= '0;
        row   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.start_i) begin
              sa     <= bus.op_a_i;
              sb     <= bus.op_b_i;
              thr_en <= bus.en_threshold_i;
              thr    <= bus.threshold_i;
              ms_run <= ms_eff;
              acc    <= '0;
              row    <= '0;
              state  <= RUN;
            end
          end
          RUN: begin
            acc <= acc_nx;
            sa  <= sa >> ms_run;
            sb  <= sb >> ms_run;
            row <= row + 3'd1;
            if (row == ms_run - 3'd1) begin
              result <= res_nx;
              done   <= 1'b1;
              state  <= DONE;
            end
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.ms_o     = ms_r;
  assign bus.busy_o   = state != IDLE;
  assign bus.stall_o  = (state == IDLE && bus.start_i
                      && !bus.flush_i) || state == RUN;
  assign bus.done_o   = done;
  assign bus.result_o = result;

endmodule

// File: tb/tb_bnn_sequencer.sv
// Randomized self-checking bench for bnn_sequencer.
// Reference: popcount of matching bits below ms*ms.
module tb_bnn_sequencer;
  localparam int DW = 32;
  localparam int AW = 6;

  logic clk;
  logic reset_n;
  int   n_chk;
  int   n_err;
  int   cur_ms;
  logic [31:0] last_res;

  bnn_sequencer_if #(.DATA_W(DW), .ACC_W(AW)) bus ();

  bnn_sequencer #(.DATA_W(DW), .MAX_MS(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(
    input int ms, input bit en,
    input logic [31:0] a, input logic [31:0] b,
    input int thr);
    int cnt;
    cnt = 0;
    for (int k = 0; k < ms*ms; k++)
      if (a[k] == b[k]) cnt++;
    if (en) return (cnt >= thr) ? 32'd1 : 32'd0;
`ifdef BNN_SEQ_BIPOLAR_EN
    return 32'(2*cnt - ms*ms);
`else
    return 32'(cnt);
`endif
  endfunction

  task automatic idle_inputs();
    bus.ms_we_i        = 1'b0;
    bus.ms_wdata_i     = 3'd0;
    bus.start_i        = 1'b0;
    bus.en_threshold_i = 1'b0;
    bus.op_a_i         = '0;
    bus.op_b_i         = '0;
    bus.threshold_i    = '0;
    bus.flush_i        = 1'b0;
  endtask

  // Called and returns just after a rising edge.
  task automatic write_ms(input int v);
    bus.ms_we_i    = 1'b1;
    bus.ms_wdata_i = 3'(v);
    @(posedge clk); #1;
    bus.ms_we_i = 1'b0;
    if (v >= 1 && v <= 5) cur_ms = v;
    check("ms_o_wr", 32'(bus.ms_o), 32'(cur_ms));
  endtask

  task automatic run_op(input bit byp, input int msb,
                        input bit en,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input int thr);
    int eff;
    logic [31:0] exp;
    if (byp) begin
      bus.ms_we_i    = 1'b1;
      bus.ms_wdata_i = 3'(msb);
      if (msb >= 1 && msb <= 5) cur_ms = msb;
    end
    eff = cur_ms;
    exp = model(eff, en, a, b, thr);
    bus.start_i        = 1'b1;
    bus.en_threshold_i = en;
    bus.op_a_i         = a;
    bus.op_b_i         = b;
    bus.threshold_i    = 6'(thr);
    @(negedge clk);
    check("stall_c0", 32'(bus.stall_o), 32'd1);
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    bus.ms_we_i = 1'b0;
    for (int c = 1; c <= eff + 1; c++) begin
      @(negedge clk);
      check("stall", 32'(bus.stall_o),
            32'(c <= eff));
      check("done", 32'(bus.done_o),
            32'(c == eff + 1));
      if (c == eff + 1)
        check("result", bus.result_o, exp);
      @(posedge clk); #1;
    end
    check("idle_after", 32'(bus.busy_o), 32'd0);
    last_res = exp;
  endtask

  initial begin
    int ms;
    bit byp;
    bit seen;
    n_chk    = 0;
    n_err    = 0;
    cur_ms   = 5;
    last_res = '0;
    idle_inputs();
    reset_n = 1'b0;
    #12;
    check("rst_ms", 32'(bus.ms_o), 32'd5);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_done", 32'(bus.done_o), 32'd0);
    check("rst_stall", 32'(bus.stall_o), 32'd0);
    check("rst_res", bus.result_o, 32'd0);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;

    write_ms(3);
    write_ms(0);
    write_ms(7);

    run_op(0, 0, 0, 32'h1FF, 32'h1FF, 0);
    run_op(0, 0, 0, 32'h1FF, 32'h0, 0);
    run_op(0, 0, 0, 32'hFFFFFE00, 32'h0, 0);
    run_op(0, 0, 1, 32'h157, 32'h056, 7);
    run_op(0, 0, 1, 32'h157, 32'h056, 8);

    // Flush during RUN row 1.
    bus.start_i = 1'b1;
    bus.op_a_i  = 32'h1FF;
    bus.op_b_i  = 32'h1FF;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    check("fl_busy", 32'(bus.busy_o), 32'd0);
    check("fl_res", bus.result_o, last_res);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done_o) seen = 1'b1;
    end
    check("fl_nodone", 32'(seen), 32'd0);
    @(posedge clk); #1;

    // Flush with start in IDLE.
    bus.start_i = 1'b1;
    bus.flush_i = 1'b1;
    #2;
    check("fs_stall", 32'(bus.stall_o), 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    check("fs_busy", 32'(bus.busy_o), 32'd0);

    // Bypass ms=2 with start: done in cycle 3.
    run_op(1, 2, 0, 32'h0000000F, 32'h00000005, 0);

    // Reset mid-RUN.
    bus.start_i = 1'b1;
    bus.op_a_i  = 32'h3;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    cur_ms   = 5;
    last_res = '0;
    check("mr_ms", 32'(bus.ms_o), 32'd5);
    check("mr_busy", 32'(bus.busy_o), 32'd0);
    check("mr_res", bus.result_o, 32'd0);
    #3 reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done_o) seen = 1'b1;
    end
    check("mr_nodone", 32'(seen), 32'd0);
    @(posedge clk); #1;
    idle_inputs();

    for (int t = 0; t < 40; t++) begin
      ms  = int'($urandom_range(1, 5));
      byp = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0)
        write_ms(int'($urandom_range(6, 7)));
      if (!byp && ms != cur_ms) write_ms(ms);
      run_op(byp, ms, 1'($urandom_range(0, 1)),
             $urandom, $urandom,
             int'($urandom_range(0, 26)));
    end

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
